// File: rtl/lcd_cmd_issuer.sv
// Command-side initiator for the LCD image controller: FIFO-buffered opcodes, one strobe per busy window.
// Optional build macro CMD_TIMEOUT_EN re-strobes a command the controller never acknowledged.
module lcd_cmd_issuer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push_valid,
    input  logic [3:0]                    push_cmd,
    output logic                          push_ready,
    input  logic                          busy,
    input  logic                          done,
    output logic [3:0]                    cmd,
    output logic                          cmd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              issued_cnt,
    output logic                          err_illegal,
    output logic                          finished
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_IDLE, WAIT_DONE, FINISH} state_t;
    state_t state, state_nx;

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [3:0]    head;
    logic          busy_q;
    logic          full, empty, push, pop, head_legal;
    logic          strobe_new, restrobe, drop, set_fin, to_expire;

    assign full       = (level == (AW+1)'(FIFO_DEPTH));
    assign empty      = (level == '0);
    assign push_ready = !full && (state != FINISH);
    assign push       = push_valid && push_ready;
    assign head       = mem[rd_ptr];
    assign head_legal = (head < 4'd12);
    assign fifo_level = level;

    // busy comes from the controller's clock domain logic; register it once so every
    // decision sees the same sampled value (this is the extra cycle of issue latency).
    always_ff @(posedge clk or posedge reset)
        if (reset) busy_q <= 1'b1;
        else       busy_q <= busy;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk or posedge reset)
        if (reset)                  to_cnt <= '0;
        else if (state != WAIT_ACK) to_cnt <= '0;
        else if (!busy_q)           to_cnt <= to_cnt + 1'b1;

    assign to_expire = (state == WAIT_ACK) && !busy_q && (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign to_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (!busy_q && !empty && head_legal) state_nx = ISSUE;
            ISSUE:     state_nx = (cmd == 4'd0) ? WAIT_DONE : WAIT_ACK;
            WAIT_ACK:  if (busy_q)         state_nx = WAIT_IDLE;
                       else if (to_expire) state_nx = ISSUE;
            WAIT_IDLE: if (!busy_q) state_nx = IDLE;
            WAIT_DONE: if (done)    state_nx = FINISH;
            FINISH:    state_nx = FINISH;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        pop        = (state == IDLE) && !busy_q && !empty;
        strobe_new = pop && head_legal;
        drop       = pop && !head_legal;
        restrobe   = to_expire;
        set_fin    = (state == WAIT_DONE) && done;
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= push_cmd;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cmd         <= 4'd0;
            cmd_valid   <= 1'b0;
            issued_cnt  <= '0;
            err_illegal <= 1'b0;
            finished    <= 1'b0;
        end else begin
            if (strobe_new) cmd <= head;
            cmd_valid <= strobe_new || restrobe;
            if (strobe_new) issued_cnt <= issued_cnt + 1'b1;
            if (drop)       err_illegal <= 1'b1;
            if (set_fin)    finished <= 1'b1;
        end
endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Bench for lcd_cmd_issuer: cycle table for issue latency, then directed multi-cycle sequences.
module tb_lcd_cmd_issuer;
    logic       clk = 1'b0;
    logic       reset;
    logic       push_valid;
    logic [3:0] push_cmd;
    logic       push_ready;
    logic       busy, busy_drv, busy_m, model_en;
    logic       done;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic [3:0] fifo_level;
    logic [7:0] issued_cnt;
    logic       err_illegal;
    logic       finished;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign busy = model_en ? busy_m : busy_drv;

    lcd_cmd_issuer dut (
        .clk(clk), .reset(reset), .push_valid(push_valid), .push_cmd(push_cmd),
        .push_ready(push_ready), .busy(busy), .done(done), .cmd(cmd), .cmd_valid(cmd_valid),
        .fifo_level(fifo_level), .issued_cnt(issued_cnt), .err_illegal(err_illegal),
        .finished(finished)
    );

    // Controller model: busy pulses for one cycle after every sampled strobe.
    always @(posedge clk) busy_m <= model_en && cmd_valid;

    // Strobe monitor: records every strobe, back-to-back strobes, and strobes with no busy between.
    logic [3:0] strobe_cmd [256];
    int         strobe_cyc [256];
    int         n_str = 0, cyc = 0, viol = 0, dbl = 0;
    logic       prev_cv = 1'b0, armed = 1'b0, busy_seen = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        prev_cv <= cmd_valid;
        if (cmd_valid) begin
            if (n_str < 256) begin
                strobe_cmd[n_str] <= cmd;
                strobe_cyc[n_str] <= cyc;
            end
            n_str     <= n_str + 1;
            if (prev_cv) dbl <= dbl + 1;
            if (armed && !busy_seen) viol <= viol + 1;
            armed     <= 1'b1;
            busy_seen <= 1'b0;
        end else if (busy) begin
            busy_seen <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        push_valid = 1'b0;
        push_cmd   = 4'd0;
        done       = 1'b0;
        model_en   = 1'b0;
        busy_drv   = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic push1(input logic [3:0] c);
        push_valid = 1'b1;
        push_cmd   = c;
        @(negedge clk);
        push_valid = 1'b0;
    endtask

    task automatic wait_str(input int target, input string nm);
        int k = 0;
        while (n_str < target && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(n_str >= target), 1);
    endtask

    typedef struct {
        logic       busy;
        logic       pv;
        logic [3:0] pc;
        logic       e_cv;
        logic [3:0] e_cmd;
        logic [3:0] e_lvl;
        logic       e_rdy;
        logic [7:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic b, input logic pv, input logic [3:0] pc,
                                input logic cv, input logic [3:0] c, input logic [3:0] l,
                                input logic r, input logic [7:0] n);
        vec_t v;
        v.busy = b; v.pv = pv; v.pc = pc;
        v.e_cv = cv; v.e_cmd = c; v.e_lvl = l; v.e_rdy = r; v.e_cnt = n;
        return v;
    endfunction

    initial begin
        vec_t vt [10];
        logic [3:0] fill [9];
        int base, cnt0;

        // Expected outputs are what the DUT shows before the vector's inputs reach an edge.
        vt[0] = mk(1, 1, 5,  0, 0, 0, 1, 0);
        vt[1] = mk(0, 0, 0,  0, 0, 1, 1, 0);
        vt[2] = mk(0, 0, 0,  0, 0, 1, 1, 0);
        vt[3] = mk(0, 0, 0,  1, 5, 0, 1, 1);
        vt[4] = mk(1, 0, 0,  0, 5, 0, 1, 1);
        vt[5] = mk(0, 0, 0,  0, 5, 0, 1, 1);
        vt[6] = mk(0, 1, 3,  0, 5, 0, 1, 1);
        vt[7] = mk(0, 0, 0,  0, 5, 1, 1, 1);
        vt[8] = mk(0, 0, 0,  1, 3, 0, 1, 2);
        vt[9] = mk(0, 0, 0,  0, 3, 0, 1, 2);

        reset = 1'b1; push_valid = 1'b0; push_cmd = 4'd0; done = 1'b0;
        model_en = 1'b0; busy_drv = 1'b1;
        @(negedge clk);
        chk("rst cmd", cmd, 0);
        chk("rst cmd_valid", cmd_valid, 0);
        chk("rst issued_cnt", issued_cnt, 0);
        chk("rst err_illegal", err_illegal, 0);
        chk("rst finished", finished, 0);
        chk("rst fifo_level", fifo_level, 0);
        chk("rst push_ready", push_ready, 1);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d cmd_valid", i), cmd_valid, vt[i].e_cv);
            chk($sformatf("vec%0d cmd", i), cmd, vt[i].e_cmd);
            chk($sformatf("vec%0d fifo_level", i), fifo_level, vt[i].e_lvl);
            chk($sformatf("vec%0d push_ready", i), push_ready, vt[i].e_rdy);
            chk($sformatf("vec%0d issued_cnt", i), issued_cnt, vt[i].e_cnt);
            busy_drv   = vt[i].busy;
            push_valid = vt[i].pv;
            push_cmd   = vt[i].pc;
        end
        @(negedge clk);
        push_valid = 1'b0;

        // Startup gating: long busy hold, then strobe exactly two edges after busy falls.
        do_reset();
        base = n_str;
        push1(4'd5);
        repeat (100) @(negedge clk);
        chk("gate no strobe while busy", n_str - base, 0);
        busy_drv = 1'b0;
        cnt0 = 0;
        while (!cmd_valid && cnt0 < 20) begin
            @(negedge clk);
            cnt0++;
        end
        chk("gate strobe latency", cnt0, 2);
        chk("gate cmd", cmd, 5);
        chk("gate issued_cnt", issued_cnt, 1);
        @(negedge clk);
        chk("gate single strobe", cmd_valid, 0);

        // Back-to-back commands against the controller model.
        do_reset();
        model_en = 1'b1;
        base = n_str; cnt0 = viol; begin int d0 = dbl;
        push1(4'd1); push1(4'd3); push1(4'd7); push1(4'd9);
        wait_str(base + 4, "b2b strobes arrived");
        chk("b2b cmd0", strobe_cmd[base], 1);
        chk("b2b cmd1", strobe_cmd[base+1], 3);
        chk("b2b cmd2", strobe_cmd[base+2], 7);
        chk("b2b cmd3", strobe_cmd[base+3], 9);
        chk("b2b no strobe without busy", viol - cnt0, 0);
        chk("b2b no double strobe", dbl - d0, 0);
        chk("b2b issued_cnt", issued_cnt, 4);
        end

        // FIFO full plus an illegal opcode at position 2.
        do_reset();
        fill = '{4'd1, 4'd13, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        for (int i = 0; i < 9; i++) push1(fill[i]);
        chk("full push_ready", push_ready, 0);
        chk("full fifo_level", fifo_level, 8);
        base = n_str;
        model_en = 1'b1;
        wait_str(base + 7, "full strobes arrived");
        repeat (10) @(negedge clk);
        chk("full strobe count", n_str - base, 7);
        for (int i = 0; i < 7; i++) chk($sformatf("full cmd%0d", i), strobe_cmd[base+i], i + 1);
        chk("full err_illegal", err_illegal, 1);
        chk("full issued_cnt", issued_cnt, 7);
        chk("full drained", fifo_level, 0);

        // Write-back then finish; trailing opcode stays queued.
        do_reset();
        model_en = 1'b1;
        base = n_str;
        push1(4'd2); push1(4'd0); push1(4'd4);
        wait_str(base + 2, "wb strobes arrived");
        chk("wb cmd0", strobe_cmd[base], 2);
        chk("wb cmd1", strobe_cmd[base+1], 0);
        repeat (70) @(negedge clk);
        chk("wb not finished yet", finished, 0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("wb finished", finished, 1);
        push_valid = 1'b1; push_cmd = 4'd4;
        repeat (20) @(negedge clk);
        push_valid = 1'b0;
        chk("wb strobe count", n_str - base, 2);
        chk("wb push_ready", push_ready, 0);
        chk("wb fifo_level", fifo_level, 1);
        chk("wb issued_cnt", issued_cnt, 2);

        // Asynchronous reset while a strobe is on the wire.
        do_reset();
        busy_drv = 1'b0;
        push1(4'd14); push1(4'd7);
        cnt0 = 0;
        while (!cmd_valid && cnt0 < 20) begin
            @(negedge clk);
            cnt0++;
        end
        chk("mid strobe seen", cmd_valid, 1);
        chk("mid err before reset", err_illegal, 1);
        reset = 1'b1;
        #1;
        chk("mid rst cmd_valid", cmd_valid, 0);
        chk("mid rst fifo_level", fifo_level, 0);
        chk("mid rst issued_cnt", issued_cnt, 0);
        chk("mid rst err_illegal", err_illegal, 0);
        @(negedge clk);
        reset = 1'b0;
        model_en = 1'b1;
        @(negedge clk);
        base = n_str;
        push1(4'd9);
        wait_str(base + 1, "mid resume strobe");
        chk("mid resume cmd", strobe_cmd[base], 9);
        chk("mid resume issued_cnt", issued_cnt, 1);

`ifdef CMD_TIMEOUT_EN
        // Controller ignores the strobe: re-strobe after the WAIT_ACK timeout.
        do_reset();
        busy_drv = 1'b0;
        base = n_str;
        push1(4'd6);
        wait_str(base + 2, "to restrobe arrived");
        chk("to gap", strobe_cyc[base+1] - strobe_cyc[base], 17);
        chk("to cmd0", strobe_cmd[base], 6);
        chk("to cmd1", strobe_cmd[base+1], 6);
        chk("to issued_cnt", issued_cnt, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end
endmodule

// File: doc/lcd_cmd_issuer.md
Name: lcd_cmd_issuer

Overview:
- Command-side initiator for the LCD image controller. Buffers commands from an upstream source in a small FIFO.
- Drives the controller's cmd/cmd_valid inputs, one command per idle window signalled by the controller's busy output.
- Stops issuing after the write-back command (opcode 0) and reports completion when the controller's done rises.
- Sits between the host/sequencer and the LCD controller in the image-processing subsystem.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries (power of two, >=2)
- CNT_W, 8, width of issued-command counter
- TIMEOUT_CYC, 16, cycles to wait for busy acknowledge (used only with CMD_TIMEOUT_EN)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- push_valid  input  1  upstream command valid
- push_cmd  input  4  upstream opcode
- push_ready  output  1  FIFO can accept; push occurs when push_valid && push_ready at a rising edge
- busy  input  1  controller busy; low = controller accepting a command
- done  input  1  controller finished writing IRAM
- cmd  output  4  opcode to controller
- cmd_valid  output  1  one-cycle command strobe
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- issued_cnt  output  CNT_W  commands issued since reset; wraps modulo 2^CNT_W
- err_illegal  output  1  sticky flag: an opcode 12..15 was dropped
- finished  output  1  high after done was observed following a write command

Behaviour:
- Reset (async) values:
  - cmd=0, cmd_valid=0, issued_cnt=0, err_illegal=0, finished=0, fifo_level=0, push_ready=1.
  - FIFO pointers cleared; state IDLE.
  - Reset mid-operation aborts any command; cmd_valid drops immediately.
- FIFO:
  - push_ready = !full && state!=FINISH.
  - A push while full is ignored. A pop occurs only in IDLE.
  - A simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine, all outputs registered:
  - IDLE: at an edge where busy==0 and FIFO non-empty, pop the head.
    - Head legal (0..11): cmd<=head, cmd_valid<=1, issued_cnt+=1, go to ISSUE.
    - Head illegal (12..15): err_illegal<=1, no strobe, stay in IDLE. Each illegal entry costs one cycle.
    - busy==1 or FIFO empty: hold.
  - ISSUE: cmd_valid is high for exactly this cycle; cmd_valid<=0 at the next edge.
    - Go to WAIT_DONE if cmd==0, else WAIT_ACK.
  - WAIT_ACK: wait until busy==1 is sampled, then go to WAIT_IDLE.
  - WAIT_IDLE: wait until busy==0 is sampled, then go to IDLE.
    - A new strobe therefore requires a full busy high->low cycle after each command.
  - WAIT_DONE: wait for done==1, then finished<=1 and go to FINISH.
  - FINISH: terminal until reset.
    - No pops or pushes; remaining FIFO contents are held and not issued.
- Latency: busy low with a non-empty FIFO sampled at edge N gives cmd_valid high between edges N+1 and N+2. The controller samples the strobe at edge N+2.
- cmd holds its last value when cmd_valid is low.
- A busy glitch low during ISSUE has no effect; only WAIT_ACK/WAIT_IDLE examine busy.
- done asserted outside WAIT_DONE is ignored.

Optional Feature:
- Macro CMD_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_ACK. If busy is not sampled high within TIMEOUT_CYC cycles, the block returns to ISSUE and re-strobes the same cmd.
  - issued_cnt is not incremented on a re-strobe.
  - Counter cleared on entry to WAIT_ACK.
- Undefined: WAIT_ACK waits indefinitely; no timeout logic is synthesised.

Test Plan:
- Startup gating:
  - Stimulus: hold busy=1 for 100 cycles after reset; push opcode 5; release busy.
  - Response: no cmd_valid while busy=1. cmd_valid pulses once with cmd=5 two edges after busy low; issued_cnt=1.
- Back-to-back commands:
  - Stimulus: push 1,3,7,9. A controller model raises busy one cycle after each strobe for one cycle.
  - Response: four single-cycle strobes in order 1,3,7,9; no two strobes without an intervening busy high; issued_cnt=4.
- FIFO full and illegal opcodes:
  - Stimulus: with busy=1, push 9 commands, including opcode 13 at position 2.
  - Response: push_ready=0 after 8 accepted and fifo_level=8; the 9th is not stored.
  - After busy low: opcode 13 is skipped with err_illegal=1 sticky; 7 strobes issued.
- Write and finish:
  - Stimulus: push 2 then 0 then 4. Model raises done 70 cycles after the cmd=0 strobe.
  - Response: strobes for 2 and 0 only. finished=1 one edge after done. push_ready=0, opcode 4 never issued, fifo_level=1.
- Reset mid-operation:
  - Stimulus: assert reset during ISSUE (cmd_valid=1).
  - Response: cmd_valid=0, fifo_level=0, issued_cnt=0, err_illegal=0 immediately; normal operation after release.
- Timeout (CMD_TIMEOUT_EN defined):
  - Stimulus: model ignores the first strobe of cmd=6 (busy stays 0).
  - Response: re-strobe of cmd=6 after 16 WAIT_ACK cycles; issued_cnt stays 1.
